// File: rtl/opponent_decoder_if.sv
// ============================================================================
// Module : opponent_decoder_if
// Brief  : Dibit receive stream in, decoded opponent state and counters out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface opponent_decoder_if;
    logic        axiov_in;
    logic [1:0]  axiod_in;
    logic [10:0] opponent_x;
    logic [10:0] opponent_y;
    logic [8:0]  direction;
    logic        game_stat;
    logic        update_out;
    logic [7:0]  frame_count;
    logic [7:0]  error_count;

    modport master (
        output axiov_in, axiod_in,
        input  opponent_x, opponent_y, direction, game_stat,
        input  update_out, frame_count, error_count
    );

    modport slave (
        input  axiov_in, axiod_in,
        output opponent_x, opponent_y, direction, game_stat,
        output update_out, frame_count, error_count
    );
endinterface

`default_nettype wire

// File: rtl/opponent_decoder.sv
// ============================================================================
// Module : opponent_decoder
// Brief  : Decodes a 16-dibit opponent frame into position/heading/status.
//          Optional macro CHECKSUM_EN adds a 4-dibit XOR checksum stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module opponent_decoder (
    input  wire logic         clk_in,
    input  wire logic         rst_in,
    opponent_decoder_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PAYLOAD = 3'd1,
`ifdef CHECKSUM_EN
        S_CHECK   = 3'd2,
`endif
        S_COMMIT  = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [31:0] r_word;
    logic [3:0]  r_cnt;
    logic        r_prev_axiov;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic [8:0]  r_dir;
    logic        r_stat;
    logic        r_update;
    logic [7:0]  r_frame_cnt;
    logic [7:0]  r_error_cnt;

    logic [31:0] w_word_nx;
    logic [31:0] w_final;
    logic        w_start;
    logic        w_last;
    logic        w_short;
    logic        w_accept;

    assign w_word_nx = {r_word[29:0], bus.axiod_in};

`ifdef CHECKSUM_EN
    logic [7:0] r_chk;
    logic [7:0] w_chk_nx;

    assign w_chk_nx = {r_chk[5:0], bus.axiod_in};
    assign w_final  = r_word;
    assign w_accept = (w_final[9:1] < 9'd360) &&
                      (w_chk_nx == (w_final[31:24] ^ w_final[23:16] ^
                                    w_final[15:8]  ^ w_final[7:0]));
`else
    assign w_final  = w_word_nx;
    assign w_accept = (w_final[9:1] < 9'd360);
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_last     = 1'b0;
        w_short    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.axiov_in && !r_prev_axiov) begin
                    w_start    = 1'b1;
                    w_state_nx = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!bus.axiov_in) begin
                    w_short    = 1'b1;
                    w_state_nx = S_IDLE;
                end else if (r_cnt == 4'd15) begin
`ifdef CHECKSUM_EN
                    w_state_nx = S_CHECK;
`else
                    w_last     = 1'b1;
                    w_state_nx = S_COMMIT;
`endif
                end
            end
`ifdef CHECKSUM_EN
            S_CHECK: begin
                if (!bus.axiov_in) begin
                    w_short    = 1'b1;
                    w_state_nx = S_IDLE;
                end else if (r_cnt == 4'd3) begin
                    w_last     = 1'b1;
                    w_state_nx = S_COMMIT;
                end
            end
`endif
            // A frame ending exactly on its last dibit drops axiov here, so the
            // commit cycle doubles as the drain exit to keep one idle cycle enough.
            S_COMMIT: w_state_nx = bus.axiov_in ? S_DRAIN : S_IDLE;
            S_DRAIN: begin
                if (!bus.axiov_in) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Decision is taken on the edge that samples the last dibit, so outputs
    // and the update pulse are both visible during the COMMIT cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_word       <= 32'd0;
            r_cnt        <= 4'd0;
            r_prev_axiov <= 1'b1;
            r_x          <= 11'd0;
            r_y          <= 11'd0;
            r_dir        <= 9'd0;
            r_stat       <= 1'b0;
            r_update     <= 1'b0;
            r_frame_cnt  <= 8'd0;
            r_error_cnt  <= 8'd0;
`ifdef CHECKSUM_EN
            r_chk        <= 8'd0;
`endif
        end else begin
            r_prev_axiov <= bus.axiov_in;
            r_update     <= w_last && w_accept;
            if (w_start) begin
                r_word <= w_word_nx;
                r_cnt  <= 4'd1;
            end else if (r_state == S_PAYLOAD && bus.axiov_in) begin
                r_word <= w_word_nx;
                r_cnt  <= r_cnt + 4'd1;
`ifdef CHECKSUM_EN
            end else if (r_state == S_CHECK && bus.axiov_in) begin
                r_chk <= w_chk_nx;
                r_cnt <= r_cnt + 4'd1;
`endif
            end
            if (w_last && w_accept) begin
                r_x         <= w_final[31:21];
                r_y         <= w_final[20:10];
                r_dir       <= w_final[9:1];
                r_stat      <= w_final[0];
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (((w_last && !w_accept) || w_short) && (r_error_cnt != 8'hFF)) begin
                r_error_cnt <= r_error_cnt + 8'd1;
            end
        end
    end

    assign bus.opponent_x  = r_x;
    assign bus.opponent_y  = r_y;
    assign bus.direction   = r_dir;
    assign bus.game_stat   = r_stat;
    assign bus.update_out  = r_update;
    assign bus.frame_count = r_frame_cnt;
    assign bus.error_count = r_error_cnt;

endmodule

`default_nettype wire

// File: tb/tb_opponent_decoder.sv
// ============================================================================
// Module : tb_opponent_decoder
// Brief  : Directed-vector bench for opponent_decoder (honours CHECKSUM_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_opponent_decoder;
`ifdef CHECKSUM_EN
    localparam int c_LAST = 19;
`else
    localparam int c_LAST = 15;
`endif
    localparam logic [31:0] c_WORD_A   = 32'h17E2FE1D;
    localparam logic [7:0]  c_CHK_A    = 8'h16;
    localparam logic [31:0] c_WORD_360 = 32'h17E2FED1;
    localparam logic [7:0]  c_CHK_360  = 8'hDA;
    localparam logic [31:0] c_WORD_B   = 32'h27E4FCB4;
    localparam logic [7:0]  c_CHK_B    = 8'h8B;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    int   n_pulse = 0;
    int   p0;

    opponent_decoder_if bus_if ();

    opponent_decoder dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus_if)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (bus_if.update_out) n_pulse++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drives n_dibits of {word,chk} then one idle cycle; optionally checks the
    // update pulse in the cycle after the last required dibit.
    task automatic send_frame(input logic [31:0] word, input logic [7:0] chk,
                              input int n_dibits, input logic do_chk, input logic exp_pulse);
        logic [39:0] bits;
        bits = {word, chk};
        for (int i = 0; i <= n_dibits; i++) begin
            @(posedge clk_in); #1;
            if (do_chk && i == c_LAST + 1) check("update_latency", {31'd0, bus_if.update_out}, {31'd0, exp_pulse});
            if (i < n_dibits) begin
                bus_if.axiov_in = 1'b1;
                bus_if.axiod_in = bits[39 - 2*i -: 2];
            end else begin
                bus_if.axiov_in = 1'b0;
                bus_if.axiod_in = 2'b00;
            end
        end
    endtask

    initial begin
        logic [39:0] bits;
        bus_if.axiov_in = 1'b0;
        bus_if.axiod_in = 2'b00;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_x", {21'd0, bus_if.opponent_x}, 32'd0);
        check("rst_y", {21'd0, bus_if.opponent_y}, 32'd0);
        check("rst_dir", {23'd0, bus_if.direction}, 32'd0);
        check("rst_stat", {31'd0, bus_if.game_stat}, 32'd0);
        check("rst_update", {31'd0, bus_if.update_out}, 32'd0);
        check("rst_fc", {24'd0, bus_if.frame_count}, 32'd0);
        check("rst_ec", {24'd0, bus_if.error_count}, 32'd0);
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);

        // Basic accepted frame
        p0 = n_pulse;
        send_frame(c_WORD_A, c_CHK_A, 20, 1'b1, 1'b1);
        repeat (2) @(posedge clk_in);
        #1;
        check("a_x", {21'd0, bus_if.opponent_x}, 32'd191);
        check("a_y", {21'd0, bus_if.opponent_y}, 32'd191);
        check("a_dir", {23'd0, bus_if.direction}, 32'd270);
        check("a_stat", {31'd0, bus_if.game_stat}, 32'd1);
        check("a_fc", {24'd0, bus_if.frame_count}, 32'd1);
        check("a_pulses", n_pulse - p0, 32'd1);

        // Direction 360 is rejected
        p0 = n_pulse;
        send_frame(c_WORD_360, c_CHK_360, 20, 1'b1, 1'b0);
        repeat (2) @(posedge clk_in);
        #1;
        check("d360_ec", {24'd0, bus_if.error_count}, 32'd1);
        check("d360_fc", {24'd0, bus_if.frame_count}, 32'd1);
        check("d360_dir", {23'd0, bus_if.direction}, 32'd270);
        check("d360_x", {21'd0, bus_if.opponent_x}, 32'd191);
        check("d360_pulses", n_pulse - p0, 32'd0);

        // Short frame: axiov drops after dibit 9, then a good frame
        p0 = n_pulse;
        send_frame(c_WORD_A, c_CHK_A, 10, 1'b0, 1'b0);
        @(posedge clk_in); #1;
        check("short_ec", {24'd0, bus_if.error_count}, 32'd2);
        check("short_pulses", n_pulse - p0, 32'd0);
        send_frame(c_WORD_A, c_CHK_A, 20, 1'b1, 1'b1);
        repeat (2) @(posedge clk_in);
        #1;
        check("after_short_fc", {24'd0, bus_if.frame_count}, 32'd2);

        // Back-to-back frames with a single idle cycle
        p0 = n_pulse;
        send_frame(c_WORD_A, c_CHK_A, 20, 1'b1, 1'b1);
        send_frame(c_WORD_B, c_CHK_B, 20, 1'b1, 1'b1);
        repeat (2) @(posedge clk_in);
        #1;
        check("b2b_pulses", n_pulse - p0, 32'd2);
        check("b2b_x", {21'd0, bus_if.opponent_x}, 32'd319);
        check("b2b_y", {21'd0, bus_if.opponent_y}, 32'd319);
        check("b2b_dir", {23'd0, bus_if.direction}, 32'd90);
        check("b2b_stat", {31'd0, bus_if.game_stat}, 32'd0);
        check("b2b_fc", {24'd0, bus_if.frame_count}, 32'd4);

        // Reset asserted at dibit 8, released while axiov is still high
        p0 = n_pulse;
        bits = {c_WORD_A, c_CHK_A};
        for (int i = 0; i <= 20; i++) begin
            @(posedge clk_in); #1;
            rst_in = (i == 8 || i == 9);
            if (i < 20) begin
                bus_if.axiov_in = 1'b1;
                bus_if.axiod_in = bits[39 - 2*i -: 2];
            end else begin
                bus_if.axiov_in = 1'b0;
                bus_if.axiod_in = 2'b00;
            end
        end
        @(posedge clk_in); #1;
        check("mrst_fc", {24'd0, bus_if.frame_count}, 32'd0);
        check("mrst_ec", {24'd0, bus_if.error_count}, 32'd0);
        check("mrst_x", {21'd0, bus_if.opponent_x}, 32'd0);
        check("mrst_pulses", n_pulse - p0, 32'd0);
        send_frame(c_WORD_A, c_CHK_A, 20, 1'b1, 1'b1);
        repeat (2) @(posedge clk_in);
        #1;
        check("mrst_next_fc", {24'd0, bus_if.frame_count}, 32'd1);
        check("mrst_next_x", {21'd0, bus_if.opponent_x}, 32'd191);

`ifdef CHECKSUM_EN
        // Bad checksum rejected; error counter saturates
        p0 = n_pulse;
        send_frame(c_WORD_A, 8'h17, 20, 1'b1, 1'b0);
        repeat (2) @(posedge clk_in);
        #1;
        check("badchk_ec", {24'd0, bus_if.error_count}, 32'd1);
        check("badchk_x", {21'd0, bus_if.opponent_x}, 32'd191);
        check("badchk_fc", {24'd0, bus_if.frame_count}, 32'd1);
        for (int k = 0; k < 256; k++) begin
            send_frame(c_WORD_A, 8'h17, 20, 1'b0, 1'b0);
        end
        repeat (2) @(posedge clk_in);
        #1;
        check("sat_ec", {24'd0, bus_if.error_count}, 32'd255);
        check("sat_pulses", n_pulse - p0, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
